// File: rtl/dbi_pkg.sv
// Shared definitions for the DBI prefetch queue: controller state encoding
// and the default byte stride between sequential fetches.
package dbi_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } pq_state_e;

    localparam int STEP_DEFAULT = 2;
endpackage

// File: rtl/pq_fifo.sv
// Circular FIFO backing the prefetch queue: W bits x DEPTH, synchronous clear,
// occupancy count. Storage is deliberately not reset.
module pq_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clkdbi,
    input  logic                       reset_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = wdata;
                wr_d        = wr_q + PW'(1);
            end
            if (pop) rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clkdbi) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clkdbi or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata = mem_q[rd_q];
    assign level = cnt_q;
endmodule

// File: rtl/dbi_prefetch_queue.sv
// Sequential instruction prefetcher: one bus read in flight, results queued
// as {data, addr, err}; flush restarts the stream and discards stale replies.
module dbi_prefetch_queue
    import dbi_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int STEP  = STEP_DEFAULT
) (
    input  logic                       clkdbi,
    input  logic                       reset_n,
    input  logic                       cedbi,
    input  logic                       flush,
    input  logic [15:0]                flush_addr,
    output logic                       bus_req,
    output logic [15:0]                bus_addr,
    input  logic                       bus_ack,
    input  logic [WIDTH-1:0]           bus_data,
    input  logic                       bus_err,
    output logic                       q_valid,
    output logic [WIDTH-1:0]           q_data,
    output logic [15:0]                q_addr,
    output logic                       q_err,
    input  logic                       q_pop,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int EW = WIDTH + 17;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    pq_state_e     state_q, state_d;
    logic [15:0]   fetch_q, fetch_d;
    logic [15:0]   addr_q, addr_d;
    logic          bus_req_q, bus_req_d;
    logic          fifo_push, fifo_pop, fifo_clr;
    logic [EW-1:0] wdata, rdata;
    logic [LW-1:0] lvl;

    always_comb begin
        state_d   = state_q;
        fetch_d   = fetch_q;
        addr_d    = addr_q;
        fifo_push = 1'b0;
        fifo_pop  = q_pop && (lvl != '0);
        fifo_clr  = 1'b0;

        unique case (state_q)
            // Only enter REQ with a free slot, so the reply always fits.
            ST_IDLE: if (!flush && (lvl < FULL)) begin
                state_d = ST_REQ;
                addr_d  = fetch_q;
            end
            ST_REQ: if (bus_ack) begin
                fifo_push = 1'b1;
                if (bus_err) begin
                    state_d = ST_HALT;
                end else begin
                    fetch_d = fetch_q + 16'(STEP);
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: if (bus_ack) state_d = ST_IDLE;
            ST_HALT:  ;
        endcase

        if (flush) begin
            fifo_clr  = 1'b1;
            fifo_push = 1'b0;
            fifo_pop  = 1'b0;
            fetch_d   = flush_addr;
            // DRAIN keeps its own exit rule; elsewhere an unanswered read must be drained.
            if (state_q != ST_DRAIN)
                state_d = (state_q == ST_REQ && !bus_ack) ? ST_DRAIN : ST_IDLE;
        end

        if (!cedbi) begin
            state_d   = state_q;
            fetch_d   = fetch_q;
            addr_d    = addr_q;
            fifo_push = 1'b0;
            fifo_pop  = 1'b0;
            fifo_clr  = 1'b0;
        end

        bus_req_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clkdbi or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            fetch_q   <= '0;
            addr_q    <= '0;
            bus_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fetch_q   <= fetch_d;
            addr_q    <= addr_d;
            bus_req_q <= bus_req_d;
        end
    end

    assign wdata = bus_err ? {{WIDTH{1'b0}}, addr_q, 1'b1} : {bus_data, addr_q, 1'b0};

    pq_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clkdbi  (clkdbi),
        .reset_n (reset_n),
        .clr     (fifo_clr),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (wdata),
        .rdata   (rdata),
        .level   (lvl)
    );

    assign bus_req  = bus_req_q;
    assign bus_addr = addr_q;
    assign level    = lvl;
    assign q_valid  = (lvl != '0);
    assign q_err    = q_valid & rdata[0];
    assign q_addr   = rdata[16:1];
    assign q_data   = rdata[EW-1:17];
endmodule
